// File: rtl/sipo_stream.sv
// sipo_stream: serial-to-parallel packer with valid/ready output and partial-word flush
module sipo_stream #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_serial_i,
  input  logic              valid_serial_i,
  output logic              ready_serial_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] word_o,
  output logic [CNT_W-1:0]  word_bits_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              flush_busy_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
  logic [DATA_W-1:0] sr, sr_shift, partial;
  logic [CNT_W-1:0] cnt;
  logic accept, slot_free, full, exec;
  always_comb begin
    ready_serial_o = !flush_busy_o && !(cnt == LAST && word_valid_o);
    accept = valid_serial_i && ready_serial_o;
    slot_free = !word_valid_o || word_ready_i;
    full = accept && cnt == LAST;
    exec = flush_busy_o && slot_free;
    sr_shift = LSB_FIRST ? {data_serial_i, sr[DATA_W-1:1]} : {sr[DATA_W-2:0], data_serial_i};
    partial = LSB_FIRST ? sr >> (DATA_W - int'(cnt))
                        : sr & ({DATA_W{1'b1}} >> (DATA_W - int'(cnt)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      cnt <= '0;
      word_o <= '0;
      word_bits_o <= '0;
      word_valid_o <= 1'b0;
      flush_busy_o <= 1'b0;
    end else begin
      if (accept) begin
        sr <= sr_shift;
        cnt <= full ? '0 : cnt + 1'b1;
      end
      if (exec) begin
        sr <= '0;
        cnt <= '0;
      end
      flush_busy_o <= !exec && (flush_busy_o || flush_i);
      if (full) begin
        word_o <= sr_shift;
        word_bits_o <= FULL;
        word_valid_o <= 1'b1;
      end else if (exec && cnt != '0) begin
        word_o <= partial;
        word_bits_o <= cnt;
        word_valid_o <= 1'b1;
      end else if (word_ready_i) begin
        word_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_stream.sv
// tb_sipo_stream: directed checks of MSB-first and LSB-first packers driven in lockstep
module tb_sipo_stream;
  logic clk = 1'b0, rst = 1'b0, ds = 1'b0, vs = 1'b0, flush = 1'b0, rdy = 1'b1;
  logic rs0, v0, busy0, rs1, v1, busy1;
  logic [7:0] w0, w1;
  logic [3:0] b0, b1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sipo_stream #(.DATA_W(8), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .data_serial_i(ds), .valid_serial_i(vs), .ready_serial_o(rs0),
    .flush_i(flush), .word_o(w0), .word_bits_o(b0), .word_valid_o(v0),
    .word_ready_i(rdy), .flush_busy_o(busy0)
  );
  sipo_stream #(.DATA_W(8), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .data_serial_i(ds), .valid_serial_i(vs), .ready_serial_o(rs1),
    .flush_i(flush), .word_o(w1), .word_bits_o(b1), .word_valid_o(v1),
    .word_ready_i(rdy), .flush_busy_o(busy1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bit_cyc(input logic b);
    vs = 1'b1;
    ds = b;
    tick();
    vs = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) bit_cyc(p[i]);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    vs = 1'b1;
    ds = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    total++;
    if ({w0, b0, v0, busy0, rs0} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_msb got w=%h b=%0d v=%b busy=%b rs=%b want 00/0/0/0/1", w0, b0, v0, busy0, rs0);
    end
    total++;
    if ({w1, b1, v1, busy1, rs1} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_lsb got w=%h b=%0d v=%b busy=%b rs=%b want 00/0/0/0/1", w1, b1, v1, busy1, rs1);
    end
  endtask
  task automatic test_full_word();
    rdy = 1'b1;
    send_byte(8'hB2);
    total++;
    if ({w0, b0, v0} !== {8'hB2, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL full_msb got w=%h b=%0d v=%b want b2/8/1", w0, b0, v0);
    end
    total++;
    if ({w1, b1, v1} !== {8'h4D, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL full_lsb got w=%h b=%0d v=%b want 4d/8/1", w1, b1, v1);
    end
    tick();
    total++;
    if ({v0, v1} !== 2'b00) begin
      bad++;
      $display("FAIL full_one_clk got v=%b%b want 00", v0, v1);
    end
  endtask
  task automatic test_back_to_back();
    rdy = 1'b1;
    send_byte(8'hB2);
    total++;
    if ({w0, w1, v0, v1} !== {8'hB2, 8'h4D, 2'b11}) begin
      bad++;
      $display("FAIL b2b_first got w=%h/%h v=%b%b want b2/4d/11", w0, w1, v0, v1);
    end
    bit_cyc(1'b1);
    vs = 1'b1;
    total++;
    if ({v0, v1, rs0, rs1} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_gap got v=%b%b rs=%b%b want 00/11", v0, v1, rs0, rs1);
    end
    for (int i = 6; i >= 0; i--) bit_cyc(i == 0 ? 1'b1 : (i >= 5 ? 1'b1 : 1'b0));
    total++;
    if ({w0, w1, b0, v0, v1} !== {8'hE1, 8'h87, 4'd8, 2'b11}) begin
      bad++;
      $display("FAIL b2b_second got w=%h/%h b=%0d v=%b%b want e1/87/8/11", w0, w1, b0, v0, v1);
    end
    tick();
  endtask
  task automatic test_backpressure();
    rdy = 1'b0;
    send_byte(8'hB2);
    for (int i = 7; i >= 1; i--) bit_cyc(8'hE1 >> i);
    total++;
    if ({rs0, rs1, v0, w0, w1} !== {2'b00, 1'b1, 8'hB2, 8'h4D}) begin
      bad++;
      $display("FAIL bp_stall got rs=%b%b v=%b w=%h/%h want 00/1/b2/4d", rs0, rs1, v0, w0, w1);
    end
    vs = 1'b1;
    ds = 1'b1;
    tick();
    tick();
    total++;
    if ({rs0, v0, w0, b0} !== {1'b0, 1'b1, 8'hB2, 4'd8}) begin
      bad++;
      $display("FAIL bp_hold got rs=%b v=%b w=%h b=%0d want 0/1/b2/8", rs0, v0, w0, b0);
    end
    rdy = 1'b1;
    tick();
    total++;
    if ({v0, v1, rs0, rs1} !== 4'b0011) begin
      bad++;
      $display("FAIL bp_xfer got v=%b%b rs=%b%b want 00/11", v0, v1, rs0, rs1);
    end
    tick();
    vs = 1'b0;
    total++;
    if ({w0, w1, v0, v1} !== {8'hE1, 8'h87, 2'b11}) begin
      bad++;
      $display("FAIL bp_second got w=%h/%h v=%b%b want e1/87/11", w0, w1, v0, v1);
    end
    tick();
  endtask
  task automatic test_flush();
    rdy = 1'b1;
    bit_cyc(1'b1);
    bit_cyc(1'b0);
    bit_cyc(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if ({busy0, busy1, v0, rs0} !== 4'b1100) begin
      bad++;
      $display("FAIL flush_pend got busy=%b%b v=%b rs=%b want 11/0/0", busy0, busy1, v0, rs0);
    end
    tick();
    total++;
    if ({w0, b0, v0, w1, b1, v1} !== {8'h05, 4'd3, 1'b1, 8'h05, 4'd3, 1'b1}) begin
      bad++;
      $display("FAIL flush_word got %h/%0d/%b %h/%0d/%b want 05/3/1 05/3/1", w0, b0, v0, w1, b1, v1);
    end
    total++;
    if ({busy0, busy1, rs0, rs1} !== 4'b0011) begin
      bad++;
      $display("FAIL flush_done got busy=%b%b rs=%b%b want 00/11", busy0, busy1, rs0, rs1);
    end
    bit_cyc(1'b1);
    flush = 1'b1;
    bit_cyc(1'b1);
    flush = 1'b0;
    tick();
    total++;
    if ({w0, b0, v0, w1, b1, v1} !== {8'h03, 4'd2, 1'b1, 8'h03, 4'd2, 1'b1}) begin
      bad++;
      $display("FAIL flush_same_bit got %h/%0d/%b %h/%0d/%b want 03/2/1 03/2/1", w0, b0, v0, w1, b1, v1);
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++;
    if ({busy0, busy1, v0, v1} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_empty got busy=%b%b v=%b%b want 00/00", busy0, busy1, v0, v1);
    end
  endtask
  task automatic test_flush_stalled();
    rdy = 1'b0;
    send_byte(8'hB2);
    bit_cyc(1'b0);
    bit_cyc(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++;
    if ({busy0, rs0, v0, w0, busy1, rs1} !== {1'b1, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL fs_stall got busy=%b rs=%b v=%b w=%h busy1=%b rs1=%b want 1/0/1/b2/1/0", busy0, rs0, v0, w0, busy1, rs1);
    end
    rdy = 1'b1;
    tick();
    total++;
    if ({w0, b0, v0, w1, b1, v1} !== {8'h01, 4'd2, 1'b1, 8'h02, 4'd2, 1'b1}) begin
      bad++;
      $display("FAIL fs_word got %h/%0d/%b %h/%0d/%b want 01/2/1 02/2/1", w0, b0, v0, w1, b1, v1);
    end
    total++;
    if ({busy0, busy1} !== 2'b00) begin
      bad++;
      $display("FAIL fs_clear got busy=%b%b want 00", busy0, busy1);
    end
    tick();
  endtask
  task automatic test_reset_midword();
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) bit_cyc(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({w0, b0, v0, busy0, w1, b1, v1, busy1} !== 26'd0) begin
      bad++;
      $display("FAIL rst_mid got %h/%0d/%b/%b %h/%0d/%b/%b want all zero", w0, b0, v0, busy0, w1, b1, v1, busy1);
    end
    send_byte(8'hE1);
    total++;
    if ({w0, b0, v0, w1, v1} !== {8'hE1, 4'd8, 1'b1, 8'h87, 1'b1}) begin
      bad++;
      $display("FAIL rst_clean got w=%h/%h b=%0d v=%b%b want e1/87/8/11", w0, w1, b0, v0, v1);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_stalled();
    test_reset_midword();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sipo_stream.md
Name: sipo_stream

Overview:
- Parametrised serial-to-parallel converter. It is the next generation of the fixed 8-bit byte collector in the decoder output path.
- Packs a serial bit stream into DATA_W-bit words. Bit order is selectable (MSB-first or LSB-first).
- Presents words on a valid/ready output port with backpressure.
- Supports a flush that emits a partial word, right-aligned, together with its bit count.
- Sits between the Viterbi traceback bit output and downstream byte/word consumers.

Parameters:
- DATA_W, 8: output word width in bits; legal range 2..64.
- LSB_FIRST, 0: bit order. 0 = first received bit lands in the word MSB; 1 = first received bit lands in the word LSB.
- CNT_W, $clog2(DATA_W+1): width of word_bits_o. Derived; do not override.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: synchronous reset, active-high.
- data_serial_i, input, 1: serial data bit.
- valid_serial_i, input, 1: data_serial_i qualifier.
- ready_serial_o, output, 1: block can accept a bit this cycle.
- flush_i, input, 1: single-cycle request to emit the pending partial word.
- word_o, output, DATA_W: parallel word.
- word_bits_o, output, CNT_W: number of valid bits in word_o (DATA_W for a full word).
- word_valid_o, output, 1: word_o/word_bits_o valid.
- word_ready_i, input, 1: downstream accepts the word.
- flush_busy_o, output, 1: a flush is pending and has not yet been emitted.

Behaviour:
- Reset (rst=1 at clk edge) clears the following, regardless of other inputs; any partial word and any pending flush are discarded:
  - word_o=0, word_bits_o=0, word_valid_o=0, flush_busy_o=0
  - shift register=0, bit counter=0
- Bit acceptance:
  - A bit is accepted when valid_serial_i && ready_serial_o.
  - Rejected bits are lost; the sender must hold the bit.
  - With valid_serial_i=0, all state holds.
- ready_serial_o = !flush_busy_o && !(cnt==DATA_W-1 && word_valid_o).
  - It is driven from registers only; there is no combinational path from word_ready_i.
- Shift:
  - LSB_FIRST=0: sr <= {sr[DATA_W-2:0], bit}.
  - LSB_FIRST=1: sr <= {bit, sr[DATA_W-1:1]}.
- slot_free = !word_valid_o || word_ready_i. This is the output register load condition.
- Full word: an accepted bit with cnt==DATA_W-1 is handled as follows.
  - Next cycle: word_o = the shifted value including that bit, word_bits_o=DATA_W, word_valid_o=1, cnt=0.
  - Latency is 1 clk from the last bit to word_valid_o.
  - Back-to-back words are possible at 1 bit/clk when word_ready_i stays high.
- Output handshake:
  - word_o and word_bits_o are stable while word_valid_o && !word_ready_i.
  - word_valid_o clears on transfer unless a new word loads in the same cycle.
- Flush:
  - flush_i sets a pending flag that is visible as flush_busy_o from the next cycle.
  - A bit accepted in the same cycle as flush_i is included in the flushed word.
  - While pending and slot_free, emit the partial word: word_bits_o=cnt, cnt=0, sr=0, pending cleared.
  - Partial word is right-aligned in word_o with zero upper bits:
    - LSB_FIRST=0: the low cnt bits of sr, in arrival order MSB→LSB.
    - LSB_FIRST=1: sr >> (DATA_W-cnt), first bit at bit 0.
  - If cnt==0 when the flush would execute: no word is emitted; pending clears.
  - flush_i while already pending is ignored.
  - A flush cannot coincide with a full-word completion, because ready_serial_o is low while pending.
  - flush_i in the same cycle as the DATA_W-th bit: the full word emits normally, then the flush executes with cnt==0, which is a no-op.
- Counter: cnt runs 0..DATA_W-1 and wraps to 0 on word completion. It never reaches DATA_W.
- No overflow is possible; backpressure is exerted only via ready_serial_o.

Test Plan:
1. Reset, DATA_W=8, LSB_FIRST=0, word_ready_i=1; send 1,0,1,1,0,0,1,0 on consecutive clks → one cycle after the 8th bit: word_o=8'hB2, word_bits_o=8, word_valid_o=1 for exactly 1 clk.
2. Same bits with LSB_FIRST=1 → word_o=8'h4D; 16 continuous bits give two words on consecutive 8-clk boundaries with no lost bits.
3. word_ready_i=0 after the first word; keep valid_serial_i=1 → ready_serial_o drops when cnt==7; the 2nd word's last bit is held; raising word_ready_i transfers 8'hB2, then the 2nd word appears next clk.
4. Send 1,0,1 then flush_i → word_o=8'h05, word_bits_o=3 (LSB_FIRST=0); with LSB_FIRST=1 same bits → word_o=8'h05; flush with cnt==0 → no word_valid_o, flush_busy_o clears after 1 clk.
5. Flush while output is stalled (word_valid_o=1, word_ready_i=0) → flush_busy_o=1 and ready_serial_o=0 until transfer; partial word is emitted the cycle after word_ready_i=1.
6. Assert rst after 5 bits and with a pending flush → all outputs 0 next clk; the following 8 bits form a clean full word with no leftover bits.
